// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: pipeline-side bundle for the iterative multiply/divide unit.
//   Start      launch Op with SrcA/SrcB (sampled on the same edge)
//   Op         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SrcA/SrcB  operands (ReadData1/ReadData2)
//   MtHi/MtLo  write SrcA into HI/LO (only while not busy)
//   Busy       operation in flight, pipeline must stall
//   Done       one-cycle pulse, HI/LO hold the new result
//   HI/LO      result registers (product high/low, remainder/quotient)
// master: pipeline side; slave: the unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic             MtHi;
  logic             MtLo;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, SrcA, SrcB, MtHi, MtLo,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  Start, Op, SrcA, SrcB, MtHi, MtLo,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU with HI/LO and MTHI/MTLO.
// Ports:
//   CLK    clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    mult_div_unit_if.slave (Start/Op/SrcA/SrcB/MtHi/MtLo in,
//          Busy/Done/HI/LO out)
// Latency: Start edge, WIDTH RUN edges, one FIX edge writing HI/LO, then Done
// for one cycle. Signed ops work on magnitudes; sign is applied in FIX.
// Optional build macro MDU_FAST_MUL_EN: multiplies use a single-cycle product
// and go straight from Start to FIX (Done in the 2nd cycle); divides unchanged.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic             CLK,
  input logic             RST_N,
  mult_div_unit_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} stateT;

  stateT              state;
  logic [1:0]         opReg;
  logic               negA;
  logic               negB;
  logic [WIDTH-1:0]   rawA;
  logic [WIDTH-1:0]   magB;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;
  logic [WIDTH-1:0]   quo;
  logic [CW-1:0]      counter;
  logic               busyReg;
  logic               doneReg;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;

  // Operand capture
  logic             startSigned;
  logic             startNegA;
  logic             startNegB;
  logic [WIDTH-1:0] startMagA;
  logic [WIDTH-1:0] startMagB;

  // Iteration step
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divShift;
  logic [WIDTH+1:0]   divDiff;
  logic               divOk;
  logic [WIDTH:0]     remNext;
  logic [WIDTH-1:0]   quoNext;

  // Final sign fix-up
  logic               flip;
  logic [2*WIDTH-1:0] prodRaw;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remLow;
  logic [WIDTH-1:0]   remFix;
  logic               divByZero;

  always_comb begin
    startSigned = ~bus.Op[0];
    startNegA   = startSigned & bus.SrcA[WIDTH-1];
    startNegB   = startSigned & bus.SrcB[WIDTH-1];
    startMagA   = startNegA ? -bus.SrcA : bus.SrcA;
    startMagB   = startNegB ? -bus.SrcB : bus.SrcB;

    // Shift-add: add multiplicand into the top half when the LSB is set,
    // then shift the whole accumulator right (carry lands in the MSB).
    mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magB} : '0);
    mulNext = {mulSum, acc[WIDTH-1:1]};

    // Restoring divide: bring in the next dividend bit, subtract if it fits.
    divShift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    divDiff  = {1'b0, divShift} - {2'b00, magB};
    divOk    = ~divDiff[WIDTH+1];
    remNext  = divOk ? divDiff[WIDTH:0] : divShift;
    quoNext  = {quo[WIDTH-2:0], divOk};

    flip = negA ^ negB;
`ifdef MDU_FAST_MUL_EN
    // acc still holds {0, |SrcA|} from Start; sign applied below like the slow path.
    prodRaw = {{WIDTH{1'b0}}, acc[WIDTH-1:0]} * {{WIDTH{1'b0}}, magB};
`else
    prodRaw = acc;
`endif
    prodFix   = flip ? -prodRaw : prodRaw;
    quoFix    = flip ? -quo : quo;
    remLow    = rem[WIDTH-1:0];
    remFix    = negA ? -remLow : remLow;
    divByZero = (magB == '0);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= StIdle;
      opReg   <= '0;
      negA    <= 1'b0;
      negB    <= 1'b0;
      rawA    <= '0;
      magB    <= '0;
      acc     <= '0;
      rem     <= '0;
      quo     <= '0;
      counter <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
    end else begin
      unique case (state)
        StIdle, StDone: begin
          doneReg <= 1'b0;
          if (bus.Start) begin
            // Start wins over a simultaneous move.
            opReg   <= bus.Op;
            negA    <= startNegA;
            negB    <= startNegB;
            rawA    <= bus.SrcA;
            magB    <= startMagB;
            acc     <= {{WIDTH{1'b0}}, startMagA};
            quo     <= startMagA;
            rem     <= '0;
            counter <= '0;
            busyReg <= 1'b1;
`ifdef MDU_FAST_MUL_EN
            state   <= bus.Op[1] ? StRun : StFix;
`else
            state   <= StRun;
`endif
          end else begin
            if (bus.MtHi) hiReg <= bus.SrcA;
            if (bus.MtLo) loReg <= bus.SrcA;
            busyReg <= 1'b0;
            state   <= StIdle;
          end
        end
        StRun: begin
          if (opReg[1]) begin
            rem <= remNext;
            quo <= quoNext;
          end else begin
            acc <= mulNext;
          end
          counter <= counter + 1'b1;
          if (counter == CW'(WIDTH - 1)) state <= StFix;
        end
        StFix: begin
          if (!opReg[1]) begin
            hiReg <= prodFix[2*WIDTH-1:WIDTH];
            loReg <= prodFix[WIDTH-1:0];
          end else if (divByZero) begin
            hiReg <= rawA;
            loReg <= '1;
          end else begin
            hiReg <= remFix;
            loReg <= quoFix;
          end
          busyReg <= 1'b0;
          doneReg <= 1'b1;
          state   <= StDone;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.Busy = busyReg;
  assign bus.Done = doneReg;
  assign bus.HI   = hiReg;
  assign bus.LO   = loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors with a result scoreboard. runOp pushes
// the expected HI/LO, a monitor pops and compares on every Done pulse.
module tb_mult_div_unit;

  localparam int unsigned W = 32;
  localparam int LatIter = 34;
`ifdef MDU_FAST_MUL_EN
  localparam int LatMul = 2;
`else
  localparam int LatMul = 34;
`endif

  localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } expT;

  expT sbQ[$];
  expT monE;
  int  nChecks = 0;
  int  nFails = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest expected result.
  always @(negedge CLK) begin
    if (RST_N === 1'b1 && bus.Done === 1'b1) begin
      if (sbQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("FAIL unexpected_done: HI=0x%08h LO=0x%08h with empty scoreboard",
                 bus.HI, bus.LO);
      end else begin
        monE = sbQ.pop_front();
        check("result_hi", bus.HI, monE.hi);
        check("result_lo", bus.LO, monE.lo);
      end
    end
  end

  // Issue one op; checks latency, Busy length and that HI/LO hold until FIX.
  // disturb: pulse Start+MtHi+MtLo mid-run. withMove: MtLo alongside Start.
  task automatic runOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi, input logic [W-1:0] lo,
                       input bit disturb, input bit withMove, input int lat);
    int cyc = 0;
    int busyCnt = 0;
    bit seen = 1'b0;
    logic [W-1:0] prevHi, prevLo;
    expT e;
    @(negedge CLK);
    prevHi = bus.HI;
    prevLo = bus.LO;
    e.hi = hi;
    e.lo = lo;
    sbQ.push_back(e);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
    bus.MtLo  = withMove;
    @(negedge CLK);
    bus.Start = 1'b0;
    bus.MtLo  = 1'b0;
    bus.SrcA  = 32'hDEAD_BEEF;
    bus.SrcB  = 32'h0BAD_F00D;
    cyc = 1;
    while (!seen && cyc < 200) begin
      if (bus.Busy === 1'b1) busyCnt++;
      if (cyc == lat - 1) begin
        check("hold_hi", bus.HI, prevHi);
        check("hold_lo", bus.LO, prevLo);
      end
      if (bus.Done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (disturb && cyc == 5) begin
          bus.Start = 1'b1;
          bus.MtHi  = 1'b1;
          bus.MtLo  = 1'b1;
          bus.Op    = OpMultu;
          bus.SrcA  = 32'h5555_5555;
          bus.SrcB  = 32'h3;
        end
        if (disturb && cyc == 6) begin
          bus.Start = 1'b0;
          bus.MtHi  = 1'b0;
          bus.MtLo  = 1'b0;
        end
        @(negedge CLK);
        cyc++;
      end
    end
    if (!seen) begin
      nChecks++;
      nFails++;
      $display("FAIL done_timeout: no Done within %0d cycles, required %0d", cyc, lat);
    end else begin
      check("latency", 32'(cyc), 32'(lat));
      check("busy_cycles", 32'(busyCnt), 32'(lat - 1));
    end
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Op    = 2'b00;
    bus.SrcA  = '0;
    bus.SrcB  = '0;
    bus.MtHi  = 1'b0;
    bus.MtLo  = 1'b0;

    repeat (2) @(negedge CLK);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_done", 32'(bus.Done), 32'd0);
    check("rst_hi", bus.HI, 32'h0);
    check("rst_lo", bus.LO, 32'h0);
    RST_N = 1'b1;

    // Moves in IDLE
    @(negedge CLK);
    bus.MtHi = 1'b1;
    bus.SrcA = 32'h1234;
    @(negedge CLK);
    bus.MtHi = 1'b0;
    check("mthi_hi", bus.HI, 32'h1234);
    check("mthi_lo", bus.LO, 32'h0);
    bus.MtHi = 1'b1;
    bus.MtLo = 1'b1;
    bus.SrcA = 32'hA5A5_0F0F;
    @(negedge CLK);
    bus.MtHi = 1'b0;
    bus.MtLo = 1'b0;
    check("mtboth_hi", bus.HI, 32'hA5A5_0F0F);
    check("mtboth_lo", bus.LO, 32'hA5A5_0F0F);

    runOp(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, LatMul);
    runOp(OpMult,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0, LatMul);
    runOp(OpMult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0, LatMul);
    runOp(OpMultu, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780, 0, 0, LatMul);
    runOp(OpMult,  32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, 1, LatMul);
    runOp(OpDiv,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, LatIter);
    runOp(OpDiv,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 0, LatIter);
    runOp(OpDivu,  32'd100,       32'd7,         32'd2,         32'd14,        1, 0, LatIter);
    runOp(OpDivu,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 0, 0, LatIter);
    runOp(OpDiv,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 0, 0, LatIter);
    runOp(OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 0, 0, LatIter);

    // Still in DONE at this negedge: a move must be honoured.
    bus.MtHi = 1'b1;
    bus.SrcA = 32'h0000_CAFE;
    @(negedge CLK);
    bus.MtHi = 1'b0;
    check("mthi_done_hi", bus.HI, 32'h0000_CAFE);
    check("mthi_done_lo", bus.LO, 32'h8000_0000);

    // Reset in the middle of a DIVU: abort, clear, no result afterwards.
    bus.Start = 1'b1;
    bus.Op    = OpDivu;
    bus.SrcA  = 32'd100;
    bus.SrcB  = 32'd7;
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (10) @(negedge CLK);
    check("midrun_busy", 32'(bus.Busy), 32'd1);
    RST_N = 1'b0;
    #1;
    check("abort_busy", 32'(bus.Busy), 32'd0);
    check("abort_done", 32'(bus.Done), 32'd0);
    check("abort_hi", bus.HI, 32'h0);
    check("abort_lo", bus.LO, 32'h0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (40) @(negedge CLK);
    check("post_abort_hi", bus.HI, 32'h0);
    check("post_abort_lo", bus.LO, 32'h0);
    check("post_abort_busy", 32'(bus.Busy), 32'd0);

    runOp(OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, 0, 0, LatIter);

    repeat (3) @(negedge CLK);
    check("scoreboard_empty", 32'(sbQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

endmodule
